bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-add-3, one bit per clock) that feeds the 6-digit 7-segment scan driver.
- Converts an unsigned binary value on a start pulse and holds six packed BCD digits plus a decimal-point mask stable until the next conversion completes.
- The downstream scanner samples `data`/`point` continuously, so the outputs never change except on the single `done` cycle.

Parameters:
- BIN_W, 20, width of the binary input. Legal range 4..20. Iteration count equals BIN_W.
- MAX_DEC, 999999, largest displayable value (6 digits). Used only when saturation is enabled.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start  input  1  conversion request. Sampled only while busy=0.
- bin  input  BIN_W  unsigned binary value, captured on an accepted start
- dp_sel  input  6  decimal-point mask, captured on an accepted start. Bit5 = leftmost digit, high = point lit.
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse; new data/point/ovf become valid in this same cycle
- data  output  24  six packed BCD digits. [23:20] = most significant, [3:0] = least significant.
- point  output  6  registered copy of dp_sel, forwarded to the scan driver
- ovf  output  1  captured bin exceeded MAX_DEC. Updated with data.

Behaviour:
- Reset: synchronous and active-high. Applies in any state, including mid-conversion. Outputs after reset:
  - busy = 0, done = 0, ovf = 0.
  - data = 24'h000000, point = 6'b000000.
  - FSM returns to IDLE; the shift counter and scratch registers are cleared.
- FSM states:
  - IDLE:
    - start=1 in cycle T loads the shift register with bin and the BCD scratch with 0, captures dp_sel, and sets iteration counter = 0.
    - It also latches ovf_next = (bin > MAX_DEC) and moves to SHIFT.
    - busy is high from cycle T+1.
  - SHIFT:
    - Each cycle, every 4-bit scratch digit >= 5 gets +3 (combinational).
    - Then {scratch, shift} shifts left by 1; the MSB of the top digit is discarded and counter+1.
    - On the edge that ends iteration BIN_W-1, the block does all of the following:
      - writes data <= corrected/shifted scratch, point <= captured mask, ovf <= ovf_next;
      - sets done = 1;
      - returns to IDLE.
- Latency: start accepted in cycle T gives done=1 and new outputs in cycle T+BIN_W+1 (T+21 by default). busy is high in cycles T+1..T+BIN_W and low in the done cycle.
- Throughput: a start asserted in the done cycle is accepted, so back-to-back conversions run every BIN_W+1 cycles.
- start asserted while busy=1 is ignored. It is not queued and does not affect the conversion in flight.
- Between done pulses, data/point/ovf hold their values. Changes on bin/dp_sel after capture have no effect.
- Scratch digits never exceed 9 after correction; each data nibble is always 0..9.
- Width rule: the scratch register is 24 bits. Overflow beyond 6 digits is truncated naturally, giving value mod 10^6.
- Reset asserted mid-SHIFT aborts the conversion. No done pulse is produced and outputs go to their reset values.

Optional Feature:
- Macro: BIN2BCD_SAT_EN.
- Defined: on an accepted start with bin > MAX_DEC, the shift register is loaded with MAX_DEC instead of bin. The result is data = 24'h999999, ovf = 1.
- Undefined: bin is loaded unchanged. data = low six decimal digits (bin mod 1000000), ovf = 1 still flags the overflow.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package:
  - NUM_DIGITS = 6, BCD_W = 4, DATA_W = 24, MAX_DEC = 999999;
  - FSM state enum (IDLE, SHIFT).
  - This package is shared with the scan driver so digit count and packing stay consistent.
- One natural sub-module: bcd_add3, combinational 4-bit "if >=5 add 3" cell. Instantiated NUM_DIGITS times via generate.

Test Plan:
- Reset, then start with bin=123456, dp_sel=6'b000100 in cycle T:
  - busy=1 in T+1..T+20;
  - in T+21: done=1, data=24'h123456, point=6'b000100, ovf=0, busy=0;
  - done=0 in T+22.
- bin=0 gives data=24'h000000, ovf=0. Then bin=999999 gives data=24'h999999, ovf=0. Outputs between the two done pulses equal the first result.
- bin=1048575:
  - BIN2BCD_SAT_EN defined: data=24'h999999, ovf=1.
  - Undefined: data=24'h048575, ovf=1.
- bin=111111 started at T; start with bin=222222 asserted at T+5 (busy) is ignored.
  - T+21: data=24'h111111.
  - start with bin=222222 in T+21 is accepted: done at T+42 with data=24'h222222.
- Sequence: convert 654321 to completion, then start 000042 and assert rst at T+10. Required:
  - from T+11: busy=0, done=0, data=0, point=0, ovf=0;
  - no done pulse is seen afterwards;
  - a fresh start converts correctly.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and FSM state type for the BCD converter and the 6-digit scan driver.
// Digit count and packing live here so both sides stay consistent.
package bin2bcd_seq_pkg;

   localparam int unsigned NUM_DIGITS = 6;
   localparam int unsigned BCD_W      = 4;
   localparam int unsigned DATA_W     = NUM_DIGITS * BCD_W;
   localparam int unsigned MAX_DEC    = 999999;

   typedef enum logic [0:0] {
      StIdle,
      StShift
   } state_e;

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Combinational shift-add-3 correction cell: a BCD digit of 5 or more gets +3.
module bin2bcd_seq_bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   always_comb begin
      dout = din;
      if (din >= 4'd5) begin
         dout = din + 4'd3;
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock; outputs change only on the done cycle.
// Define BIN2BCD_SAT_EN to clamp inputs above MAX_DEC to 999999 instead of wrapping mod 10^6.
module bin2bcd_seq #(
   parameter int unsigned BIN_W   = 20,
   parameter int unsigned MAX_DEC = bin2bcd_seq_pkg::MAX_DEC
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [BIN_W-1:0]                    bin,
   input  logic [bin2bcd_seq_pkg::NUM_DIGITS-1:0] dp_sel,
   output logic                                busy,
   output logic                                done,
   output logic [bin2bcd_seq_pkg::DATA_W-1:0]  data,
   output logic [bin2bcd_seq_pkg::NUM_DIGITS-1:0] point,
   output logic                                ovf
);

   import bin2bcd_seq_pkg::*;

   localparam int unsigned CNT_W = $clog2(BIN_W);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [BIN_W-1:0]        shift_q, shift_d;
   logic [DATA_W-1:0]       scratch_q, scratch_d;
   logic [DATA_W-1:0]       corr;
   logic [NUM_DIGITS-1:0]   mask_q, mask_d;
   logic                    ovf_next_q, ovf_next_d;
   logic [DATA_W-1:0]       data_q, data_d;
   logic [NUM_DIGITS-1:0]   point_q, point_d;
   logic                    ovf_q, ovf_d;
   logic                    done_q, done_d;
   logic                    bin_over;
   logic [BIN_W-1:0]        load_val;

   assign bin_over = 32'(bin) > MAX_DEC;

`ifdef BIN2BCD_SAT_EN
   localparam logic [31:0] MaxDecVec = 32'(MAX_DEC);
   assign load_val = bin_over ? MaxDecVec[BIN_W-1:0] : bin;
`else
   assign load_val = bin;
`endif

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bin2bcd_seq_bcd_add3 u_add3 (
         .din  (scratch_q[g*BCD_W +: BCD_W]),
         .dout (corr[g*BCD_W +: BCD_W])
      );
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      scratch_d  = scratch_q;
      mask_d     = mask_q;
      ovf_next_d = ovf_next_q;
      data_d     = data_q;
      point_d    = point_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               shift_d    = load_val;
               scratch_d  = '0;
               mask_d     = dp_sel;
               ovf_next_d = bin_over;
               cnt_d      = '0;
               state_d    = StShift;
            end
         end
         StShift: begin
            // Top bit of the most significant digit falls off: result is value mod 10^6.
            {scratch_d, shift_d} = {corr[DATA_W-2:0], shift_q, 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               data_d  = scratch_d;
               point_d = mask_q;
               ovf_d   = ovf_next_q;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         shift_q    <= '0;
         scratch_q  <= '0;
         mask_q     <= '0;
         ovf_next_q <= 1'b0;
         data_q     <= '0;
         point_q    <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         scratch_q  <= scratch_d;
         mask_q     <= mask_d;
         ovf_next_q <= ovf_next_d;
         data_q     <= data_d;
         point_q    <= point_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
      end
   end

   assign busy  = (state_q == StShift);
   assign done  = done_q;
   assign data  = data_q;
   assign point = point_q;
   assign ovf   = ovf_q;

endmodule
